load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_lane.sv | 51 +++++
 rtl/load_store_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// funct3 codes, FSM encoding, request checking.
package lsu_pkg;

  localparam int MEM_WORDS_DEF = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Misaligned, illegal width code or word index past the memory.
  function automatic logic req_err(
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input int          words
  );
    logic e;
    if (st) e = (f3 > F3_W);
    else    e = (f3 == 3'b011) || (f3 == 3'b110)
             || (f3 == 3'b111);
    if ((f3 == F3_H || f3 == F3_HU) && a[0])
      e = 1'b1;
    if (f3 == F3_W && a[1:0] != 2'b00)
      e = 1'b1;
    if ({2'b00, a[31:2]} >= 32'(words))
      e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: load extraction
// and read-modify-write store merging.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] write_data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{addr_lo, 3'b000} +: 8];
  assign h = addr_lo[1] ? word[31:16] : word[15:0];

  // Sign/zero-extend the selected lane of the read word.
  always_comb begin
    load_data = '0;
    unique case (funct3)
      F3_B:    load_data = {{24{b[7]}}, b};
      F3_H:    load_data = {{16{h[15]}}, h};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, b};
      F3_HU:   load_data = {16'd0, h};
      default: load_data = '0;
    endcase
  end

  // Replace only the addressed lane for sub-word stores.
  always_comb begin
    write_data = store_data;
    unique case (funct3)
      F3_B: begin
        write_data = word;
        write_data[{addr_lo, 3'b000} +: 8] =
          store_data[7:0];
      end
      F3_H: begin
        write_data = word;
        write_data[{addr_lo[1], 4'b0000} +: 16] =
          store_data[15:0];
      end
      default: write_data = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with a single-word
// synchronous data memory port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  state_t      state, state_nxt;
  logic        r_store, r_err;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_sdata, r_word;
  logic [31:0] ld_ext, wd_merge;
  logic        req_bad, mem_cyc;

  assign req_bad =
    req_err(is_store, funct3, addr, MEM_WORDS);

  // State and request registers; start only in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      r_store <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_sdata <= '0;
      r_word  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        r_store <= is_store;
        r_err   <= req_bad;
        r_f3    <= funct3;
        r_addr  <= addr;
        r_sdata <= store_data;
      end
      if (state == S_READ)
        r_word <= mem_RD;
    end
  end

  // Next state: sw skips READ, sub-word stores read first.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (req_bad)
            state_nxt = S_DONE;
          else if (is_store && funct3 == F3_W)
            state_nxt = S_WRITE;
          else
            state_nxt = S_READ;
        end
      end
      S_READ:
        state_nxt = r_store ? S_WRITE : S_DONE;
      S_WRITE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  lsu_lane u_lane (
    .funct3     (r_f3),
    .addr_lo    (r_addr[1:0]),
    .word       (r_word),
    .store_data (r_sdata),
    .load_data  (ld_ext),
    .write_data (wd_merge)
  );

  assign mem_cyc = (state == S_READ)
                || (state == S_WRITE);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = done && r_err;

  assign load_data =
    (done && !r_err && !r_store) ? ld_ext : '0;

  assign mem_A  =
    mem_cyc ? {2'b00, r_addr[31:2]} : '0;
  assign mem_WD =
    (state == S_WRITE) ? wd_merge : '0;
  assign mem_WE = (state == S_WRITE) && !rst;

endmodule
